// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back controller.
package regfile_pkg;

  localparam int XLEN    = 32;
  localparam int NREG    = 32;
  localparam int RADDR_W = $clog2(NREG);

  localparam logic [RADDR_W-1:0] REG_ZERO = 5'd0;

  // Identifies which writeback requester owns a grant.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_t;

  // One-hot decode of a register address into a scoreboard-wide mask.
  function automatic logic [NREG-1:0] reg_onehot(input logic [RADDR_W-1:0] r);
    reg_onehot = {{(NREG-1){1'b0}}, 1'b1} << r;
  endfunction

endpackage

// File: rtl/wb_arb2.sv
// Two-way writeback arbiter (ALU = A, load unit = B).
// Policy macro WBCTRL_ROUND_ROBIN_EN:
//   defined   -> round-robin, a one-bit pointer remembers the last winner
//                and only moves on a grant; reset value lets A win first.
//   undefined -> fixed priority, B over A, no state (no clock port).
// Grants are forced low while rstn is asserted.
module wb_arb2
  import regfile_pkg::*;
(
`ifdef WBCTRL_ROUND_ROBIN_EN
  input  logic clk,
`endif
  input  logic rstn,
  input  logic a_valid_i,
  input  logic b_valid_i,
  output logic a_gnt_o,
  output logic b_gnt_o
);

`ifdef WBCTRL_ROUND_ROBIN_EN
  src_t last_q;
  src_t last_d;

  // Grant selection: single requester wins, contention goes to the non-last winner.
  always_comb begin
    a_gnt_o = 1'b0;
    b_gnt_o = 1'b0;
    last_d  = last_q;
    if (!rstn) begin
      a_gnt_o = 1'b0;
      b_gnt_o = 1'b0;
    end else if (a_valid_i && b_valid_i) begin
      a_gnt_o = (last_q == SRC_LSU);
      b_gnt_o = (last_q == SRC_ALU);
    end else begin
      a_gnt_o = a_valid_i;
      b_gnt_o = b_valid_i;
    end
    if (a_gnt_o) begin
      last_d = SRC_ALU;
    end else if (b_gnt_o) begin
      last_d = SRC_LSU;
    end else begin
      last_d = last_q;
    end
  end

  // Last-winner pointer; resetting to LSU makes A win the first contention.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_q <= SRC_LSU;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: the load unit always beats the ALU.
  always_comb begin
    a_gnt_o = rstn & a_valid_i & ~b_valid_i;
    b_gnt_o = rstn & b_valid_i;
  end
`endif

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: arbitrates ALU/load writes onto the single register
// file write port, registers the winning write, and tracks a busy scoreboard
// whose hazard output stalls issue. Arbitration policy is selected by the
// WBCTRL_ROUND_ROBIN_EN macro (see wb_arb2).
module regfile_wb_ctrl
  import regfile_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               a_valid,
  input  logic [RADDR_W-1:0] a_rd,
  input  logic [XLEN-1:0]    a_data,
  output logic               a_ready,
  input  logic               b_valid,
  input  logic [RADDR_W-1:0] b_rd,
  input  logic [XLEN-1:0]    b_data,
  output logic               b_ready,
  input  logic               set_en,
  input  logic [RADDR_W-1:0] set_rd,
  input  logic [RADDR_W-1:0] rs1,
  input  logic [RADDR_W-1:0] rs2,
  output logic               hazard,
  output logic               enW,
  output logic [RADDR_W-1:0] rd,
  output logic [XLEN-1:0]    in,
  output logic [NREG-1:0]    busy
);

  logic               enw_q,  enw_d;
  logic [RADDR_W-1:0] rd_q,   rd_d;
  logic [XLEN-1:0]    in_q,   in_d;
  logic [NREG-1:0]    busy_q, busy_d;

  wb_arb2 u_arb (
`ifdef WBCTRL_ROUND_ROBIN_EN
    .clk       (clk),
`endif
    .rstn      (rstn),
    .a_valid_i (a_valid),
    .b_valid_i (b_valid),
    .a_gnt_o   (a_ready),
    .b_gnt_o   (b_ready)
  );

  // Output stage next state: load the winner, drop writes aimed at x0.
  always_comb begin
    enw_d = 1'b0;
    rd_d  = rd_q;
    in_d  = in_q;
    if (b_ready) begin
      rd_d  = b_rd;
      in_d  = b_data;
      enw_d = (b_rd != REG_ZERO);
    end else if (a_ready) begin
      rd_d  = a_rd;
      in_d  = a_data;
      enw_d = (a_rd != REG_ZERO);
    end else begin
      enw_d = 1'b0;
    end
  end

  // Scoreboard next state: clear on the outgoing write, then set (set wins).
  always_comb begin
    busy_d = busy_q;
    if (enw_q) begin
      busy_d = busy_d & ~reg_onehot(rd_q);
    end else begin
      busy_d = busy_d;
    end
    if (set_en && (set_rd != REG_ZERO)) begin
      busy_d = busy_d | reg_onehot(set_rd);
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      enw_q  <= 1'b0;
      rd_q   <= REG_ZERO;
      in_q   <= {XLEN{1'b0}};
      busy_q <= {NREG{1'b0}};
    end else begin
      enw_q  <= enw_d;
      rd_q   <= rd_d;
      in_q   <= in_d;
      busy_q <= busy_d;
    end
  end

  // Hazard lookup and output wiring; busy[0] is never set so x0 is hazard-free.
  always_comb begin
    hazard = busy_q[rs1] | busy_q[rs2];
    enW    = enw_q;
    rd     = rd_q;
    in     = in_q;
    busy   = busy_q;
  end

endmodule
